// File: rtl/brick_pkg.sv
// Shared constants, widths and FSM state type for the brick field controller.
package brick_pkg;

    localparam int unsigned ROWS         = 5;
    localparam int unsigned COLS         = 10;
    localparam int unsigned BRICK_W_LOG2 = 6;
    localparam int unsigned BRICK_H_LOG2 = 4;
    localparam int unsigned FIELD_Y0     = 32;
    localparam int unsigned NB           = ROWS * COLS;

    localparam int unsigned FIELD_W      = COLS << BRICK_W_LOG2;
    localparam int unsigned FIELD_H      = ROWS << BRICK_H_LOG2;

    localparam int unsigned XY_W         = 10;
    localparam int unsigned ROW_W        = 3;
    localparam int unsigned COL_W        = 4;
    localparam int unsigned IDX_W        = 6;
    localparam int unsigned LEFT_W       = 6;
    localparam int unsigned SCORE_W      = 16;
    localparam int unsigned LEVEL_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE,
        ST_DONE,
        ST_REFILL
    } state_t;

endpackage

// File: rtl/brick_locate.sv
// Maps a pixel coordinate onto the brick grid: in-field flag, row, column, flat index.
module brick_locate
    import brick_pkg::*;
(
    input  logic [XY_W-1:0]  i_x,
    input  logic [XY_W-1:0]  i_y,
    output logic             o_in_field,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic [IDX_W-1:0] o_idx
);

    logic [XY_W-1:0] w_dy;

    // Offset into the field; wraps when above it, but o_in_field masks that case.
    assign w_dy       = i_y - XY_W'(FIELD_Y0);
    assign o_in_field = (i_y >= XY_W'(FIELD_Y0))
                     && (i_y <  XY_W'(FIELD_Y0 + FIELD_H))
                     && (i_x <  XY_W'(FIELD_W));
    assign o_row      = ROW_W'(w_dy >> BRICK_H_LOG2);
    assign o_col      = COL_W'(i_x >> BRICK_W_LOG2);
    assign o_idx      = IDX_W'(o_row) * IDX_W'(COLS) + IDX_W'(o_col);

endmodule

// File: rtl/brick_field_ctrl.sv
// Brick wall state: collision queries, kill/score bookkeeping, level refill, pixel lookup.
module brick_field_ctrl
    import brick_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hit_req,
    input  logic [XY_W-1:0]    ball_x,
    input  logic [XY_W-1:0]    ball_y,
    input  logic               new_level,
    output logic               busy,
    output logic               hit_valid,
    output logic               hit,
    output logic [ROW_W-1:0]   hit_row,
    output logic [COL_W-1:0]   hit_col,
    output logic [SCORE_W-1:0] score,
    output logic [LEFT_W-1:0]  bricks_left,
    output logic [LEVEL_W-1:0] level,
    output logic               level_clear,
    input  logic [XY_W-1:0]    pix_x,
    input  logic [XY_W-1:0]    pix_y,
    output logic               pix_brick_on
);

    state_t              r_state;
    logic [NB-1:0]       r_alive;
    logic [LEFT_W-1:0]   r_bricks_left;
    logic [SCORE_W-1:0]  r_score;
    logic [LEVEL_W-1:0]  r_level;
    logic                r_refill_pending;
    logic                r_busy;
    logic                r_hit_valid;
    logic                r_hit;
    logic [ROW_W-1:0]    r_hit_row;
    logic [COL_W-1:0]    r_hit_col;
    logic                r_level_clear;
    logic                r_pix_brick_on;

    logic [XY_W-1:0]     r_qx;
    logic [XY_W-1:0]     r_qy;
    logic                r_q_in_field;
    logic [ROW_W-1:0]    r_q_row;
    logic [COL_W-1:0]    r_q_col;
    logic [IDX_W-1:0]    r_q_idx;

    logic                w_q_in_field;
    logic [ROW_W-1:0]    w_q_row;
    logic [COL_W-1:0]    w_q_col;
    logic [IDX_W-1:0]    w_q_idx;

    logic                w_p_in_field;
    logic [ROW_W-1:0]    w_p_row;
    logic [COL_W-1:0]    w_p_col;
    logic [IDX_W-1:0]    w_p_idx;

    brick_locate u_loc_query (
        .i_x        (r_qx),
        .i_y        (r_qy),
        .o_in_field (w_q_in_field),
        .o_row      (w_q_row),
        .o_col      (w_q_col),
        .o_idx      (w_q_idx)
    );

    brick_locate u_loc_pix (
        .i_x        (pix_x),
        .i_y        (pix_y),
        .o_in_field (w_p_in_field),
        .o_row      (w_p_row),
        .o_col      (w_p_col),
        .o_idx      (w_p_idx)
    );

    // Query/refill sequencer; refill work lands on the IDLE->REFILL edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_alive          <= '1;
            r_bricks_left    <= LEFT_W'(NB);
            r_score          <= '0;
            r_level          <= '0;
            r_refill_pending <= 1'b0;
            r_busy           <= 1'b0;
            r_hit_valid      <= 1'b0;
            r_hit            <= 1'b0;
            r_hit_row        <= '0;
            r_hit_col        <= '0;
            r_level_clear    <= 1'b0;
            r_qx             <= '0;
            r_qy             <= '0;
            r_q_in_field     <= 1'b0;
            r_q_row          <= '0;
            r_q_col          <= '0;
            r_q_idx          <= '0;
        end else begin
            r_hit_valid   <= 1'b0;
            r_level_clear <= 1'b0;
            if (new_level) begin
                r_refill_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_refill_pending) begin
                        r_alive       <= '1;
                        r_bricks_left <= LEFT_W'(NB);
                        r_level       <= r_level + LEVEL_W'(1);
                        if (!new_level) begin
                            r_refill_pending <= 1'b0;
                        end
                        r_busy  <= 1'b1;
                        r_state <= ST_REFILL;
                    end else if (hit_req) begin
                        r_qx    <= ball_x;
                        r_qy    <= ball_y;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_q_in_field <= w_q_in_field;
                    r_q_row      <= w_q_row;
                    r_q_col      <= w_q_col;
                    r_q_idx      <= w_q_idx;
                    r_state      <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (r_q_in_field && r_alive[r_q_idx]) begin
                        r_alive[r_q_idx] <= 1'b0;
                        r_bricks_left    <= r_bricks_left - LEFT_W'(1);
                        if (r_score != '1) begin
                            r_score <= r_score + SCORE_W'(1);
                        end
                        r_hit     <= 1'b1;
                        r_hit_row <= r_q_row;
                        r_hit_col <= r_q_col;
                        if (r_bricks_left == LEFT_W'(1)) begin
                            r_level_clear    <= 1'b1;
                            r_refill_pending <= 1'b1;
                        end
                    end else begin
                        r_hit <= 1'b0;
                    end
                    r_hit_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_REFILL: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Renderer lookup, one cycle behind the pixel coordinate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_brick_on <= 1'b0;
        end else begin
            r_pix_brick_on <= w_p_in_field && r_alive[w_p_idx];
        end
    end

    assign busy         = r_busy;
    assign hit_valid    = r_hit_valid;
    assign hit          = r_hit;
    assign hit_row      = r_hit_row;
    assign hit_col      = r_hit_col;
    assign score        = r_score;
    assign bricks_left  = r_bricks_left;
    assign level        = r_level;
    assign level_clear  = r_level_clear;
    assign pix_brick_on = r_pix_brick_on;

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Self-checking bench for brick_field_ctrl: transaction-level model plus directed pins and random traffic.
module tb_brick_field_ctrl;

    logic        clk;
    logic        reset;
    logic        hit_req;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        new_level;
    logic        busy;
    logic        hit_valid;
    logic        hit;
    logic [2:0]  hit_row;
    logic [3:0]  hit_col;
    logic [15:0] score;
    logic [5:0]  bricks_left;
    logic [3:0]  level;
    logic        level_clear;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_brick_on;

    brick_field_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .hit_req      (hit_req),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .new_level    (new_level),
        .busy         (busy),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_row      (hit_row),
        .hit_col      (hit_col),
        .score        (score),
        .bricks_left  (bricks_left),
        .level        (level),
        .level_clear  (level_clear),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_brick_on (pix_brick_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_hv    = 0;
    int n_lc    = 0;

    // Model: brick wall as a plain array plus a transaction in flight (op/age).
    bit m_alive [50];
    int m_left, m_score, m_level;
    bit m_pend;
    int m_op;   // 0 none, 1 query, 2 refill
    int m_age;  // cycles since query accepted
    int m_qx, m_qy;
    bit e_busy, e_hv, e_hit, e_lc, e_pix;
    int e_row, e_col;

    function automatic bit in_field(int x, int y);
        return (y >= 32) && (y < 32 + 5 * 16) && (x < 10 * 64);
    endfunction

    function automatic int idx_of(int x, int y);
        return ((y - 32) / 16) * 10 + (x / 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 50; i++) m_alive[i] = 1'b1;
        m_left = 50; m_score = 0; m_level = 0; m_pend = 1'b0;
        m_op = 0; m_age = 0;
        e_busy = 0; e_hv = 0; e_hit = 0; e_lc = 0; e_pix = 0; e_row = 0; e_col = 0;
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input bit rst, input bit hr, input bit nl,
                              input int bx, input int by, input int px, input int py);
        bit p0;
        bit pix_next;
        if (rst) begin
            model_reset();
            return;
        end
        pix_next = 1'b0;
        if (in_field(px, py)) pix_next = m_alive[idx_of(px, py)];
        e_hv = 1'b0;
        e_lc = 1'b0;
        p0 = m_pend;
        if (nl) m_pend = 1'b1;
        if (m_op == 0) begin
            if (p0) begin
                for (int i = 0; i < 50; i++) m_alive[i] = 1'b1;
                m_left  = 50;
                m_level = (m_level + 1) % 16;
                m_pend  = nl;
                m_op    = 2;
            end else if (hr) begin
                m_qx = bx; m_qy = by;
                m_op = 1; m_age = 1;
            end
        end else if (m_op == 1) begin
            m_age++;
            if (m_age == 3) begin
                e_hv = 1'b1;
                if (in_field(m_qx, m_qy) && m_alive[idx_of(m_qx, m_qy)]) begin
                    m_alive[idx_of(m_qx, m_qy)] = 1'b0;
                    m_left--;
                    if (m_score < 65535) m_score++;
                    e_hit = 1'b1;
                    e_row = (m_qy - 32) / 16;
                    e_col = m_qx / 64;
                    if (m_left == 0) begin
                        e_lc   = 1'b1;
                        m_pend = 1'b1;
                    end
                end else begin
                    e_hit = 1'b0;
                end
            end
            if (m_age == 4) m_op = 0;
        end else begin
            m_op = 0;
        end
        e_busy = (m_op != 0);
        e_pix  = pix_next;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare_all();
        chk("busy",         int'(busy),         int'(e_busy));
        chk("hit_valid",    int'(hit_valid),    int'(e_hv));
        chk("level_clear",  int'(level_clear),  int'(e_lc));
        chk("score",        int'(score),        m_score);
        chk("bricks_left",  int'(bricks_left),  m_left);
        chk("level",        int'(level),        m_level);
        chk("pix_brick_on", int'(pix_brick_on), int'(e_pix));
        if (e_hv) begin
            chk("hit", int'(hit), int'(e_hit));
            if (e_hit) begin
                chk("hit_row", int'(hit_row), e_row);
                chk("hit_col", int'(hit_col), e_col);
            end
        end
        if (hit_valid === 1'b1) n_hv++;
        if (level_clear === 1'b1) n_lc++;
    endtask

    task automatic step(input bit rst, input bit hr, input bit nl,
                        input int bx, input int by, input int px, input int py);
        reset     = rst;
        hit_req   = hr;
        new_level = nl;
        ball_x    = 10'(bx);
        ball_y    = 10'(by);
        pix_x     = 10'(px);
        pix_y     = 10'(py);
        model_step(rst, hr, nl, bx, by, px, py);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 700, 0);
    endtask

    initial begin
        int hv0, lc0, lvl0;
        reset = 1'b1; hit_req = 1'b0; new_level = 1'b0;
        ball_x = '0; ball_y = '0; pix_x = '0; pix_y = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_left",  int'(bricks_left), 50);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_score", int'(score), 0);
        idle(2);

        // First kill at (70,40): row 0, col 1
        step(0, 1, 0, 70, 40, 700, 0);
        idle(2);
        chk("q1_valid", int'(hit_valid), 1);
        chk("q1_hit",   int'(hit), 1);
        chk("q1_row",   int'(hit_row), 0);
        chk("q1_col",   int'(hit_col), 1);
        chk("q1_score", int'(score), 1);
        chk("q1_left",  int'(bricks_left), 49);
        idle(1);

        // Same brick again: already dead
        step(0, 1, 0, 70, 40, 700, 0);
        idle(2);
        chk("q2_hit",   int'(hit), 0);
        chk("q2_score", int'(score), 1);
        chk("q2_left",  int'(bricks_left), 49);
        idle(1);

        // Below the field
        step(0, 1, 0, 100, 200, 700, 0);
        idle(2);
        chk("q3_valid", int'(hit_valid), 1);
        chk("q3_hit",   int'(hit), 0);
        idle(1);

        // Pixel lookups
        step(0, 0, 0, 0, 0, 70, 40);
        chk("pix_dead", int'(pix_brick_on), 0);
        step(0, 0, 0, 0, 0, 10, 40);
        chk("pix_live", int'(pix_brick_on), 1);
        step(0, 0, 0, 0, 0, 10, 20);
        chk("pix_above", int'(pix_brick_on), 0);

        // hit_req held through busy: exactly one result
        hv0 = n_hv;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 70, 50, 700, 0);
        idle(4);
        chk("busy_ignore_hv", n_hv - hv0, 1);

        // new_level during LOOKUP: query finishes, then refill
        lvl0 = int'(level);
        step(0, 1, 0, 200, 60, 700, 0);
        step(0, 0, 1, 0, 0, 700, 0);
        idle(1);
        chk("nl_valid", int'(hit_valid), 1);
        idle(2);
        chk("nl_level", int'(level), (lvl0 + 1) % 16);
        chk("nl_left",  int'(bricks_left), 50);
        chk("nl_busy",  int'(busy), 1);
        idle(2);

        // Reset while in UPDATE
        step(0, 1, 0, 200, 60, 700, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 700, 0);
        chk("rupd_valid", int'(hit_valid), 0);
        chk("rupd_left",  int'(bricks_left), 50);
        chk("rupd_score", int'(score), 0);
        chk("rupd_busy",  int'(busy), 0);
        hv0 = n_hv;
        idle(4);
        chk("rupd_no_hv", n_hv - hv0, 0);

        // Clear the whole wall
        lc0 = n_lc;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                step(0, 1, 0, c * 64 + 10, 32 + r * 16 + 5, 700, 0);
                idle(2);
                if (r == 4 && c == 9) begin
                    chk("last_lc", int'(level_clear), 1);
                    chk("last_hv", int'(hit_valid), 1);
                end
                idle(1);
            end
        end
        idle(1);
        chk("clr_left",  int'(bricks_left), 50);
        chk("clr_level", int'(level), 1);
        chk("clr_score", int'(score), 50);
        chk("clr_lc_once", n_lc - lc0, 1);
        idle(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_hr, r_nl;
            r_rst = ($urandom_range(0, 399) == 0);
            r_hr  = ($urandom_range(0, 1) == 1);
            r_nl  = ($urandom_range(0, 59) == 0);
            step(r_rst, r_hr, r_nl,
                 int'($urandom_range(0, 700)), int'($urandom_range(0, 130)),
                 int'($urandom_range(0, 700)), int'($urandom_range(0, 130)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/brick_field_ctrl.md
Name: brick_field_ctrl

Overview:
Owns the alive/dead state of the whole brick wall for the breakout game. It does three things:
- Serves collision queries from the ball/physics logic over a req/valid handshake.
- Kills a brick on a hit and keeps the score and bricks-remaining count.
- Answers a per-pixel "is a live brick here" lookup for the VGA renderer.

It also sequences level clear and refill. It sits between the ball physics block and the pixel/colour generator.

Parameters:
ROWS, 5, brick rows
COLS, 10, brick columns
BRICK_W_LOG2, 6, brick width = 64 px (power of two)
BRICK_H_LOG2, 4, brick height = 16 px (power of two)
FIELD_Y0, 32, top pixel row of the brick field
NB (localparam), ROWS*COLS = 50, number of bricks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hit_req  in  1  collision query strobe; sampled only when busy=0
ball_x  in  10  ball x, captured with hit_req
ball_y  in  10  ball y, captured with hit_req
new_level  in  1  request refill of all bricks
busy  out  1  query or refill in progress
hit_valid  out  1  one-cycle result strobe
hit  out  1  query struck a live brick (valid with hit_valid)
hit_row  out  3  row index of struck brick (valid with hit_valid)
hit_col  out  4  column index of struck brick (valid with hit_valid)
score  out  16  bricks destroyed since reset, saturating at 16'hFFFF
bricks_left  out  6  live brick count
level  out  4  level number, wraps 15->0
level_clear  out  1  one-cycle pulse when the last brick dies
pix_x  in  10  renderer pixel x
pix_y  in  10  renderer pixel y
pix_brick_on  out  1  live brick covers (pix_x, pix_y); 1-cycle latency

Behaviour:
- Reset (sync, clk edge with reset=1) sets:
  - alive[NB-1:0] all ones; bricks_left=50; score=0; level=0.
  - state IDLE; busy=0; hit_valid=0; hit=0; hit_row=0; hit_col=0; level_clear=0; refill_pending=0; pix_brick_on=0.
  - Reset in any state aborts the operation in flight; no hit_valid is issued for it.
- States: IDLE, LOOKUP, UPDATE, DONE, REFILL.
- IDLE:
  - refill_pending=1 -> REFILL.
  - else hit_req=1 -> capture ball_x/ball_y -> LOOKUP.
  - refill_pending takes priority over a simultaneous hit_req; that hit_req is dropped.
- LOOKUP:
  - in_field = (ball_y >= FIELD_Y0) && (ball_y < FIELD_Y0 + (ROWS<<BRICK_H_LOG2)) && (ball_x < (COLS<<BRICK_W_LOG2)).
  - row = (ball_y - FIELD_Y0) >> BRICK_H_LOG2; col = ball_x >> BRICK_W_LOG2; idx = row*COLS + col.
  - Register in_field, row, col, idx -> UPDATE.
- UPDATE:
  - If in_field and alive[idx]: clear alive[idx], decrement bricks_left, increment score (saturating), hit_r=1.
  - Otherwise hit_r=0 and nothing changes.
  - -> DONE.
- DONE:
  - hit_valid=1; hit/hit_row/hit_col driven from the registered values.
  - If bricks_left==0: level_clear=1 this cycle and refill_pending is set.
  - -> IDLE.
- Handshake timing: hit_req sampled at edge k gives hit_valid high in cycle k+3.
  - busy=1 for all states except IDLE, i.e. cycles k+1..k+3.
  - hit_req while busy=1 is ignored; there is no queuing.
  - hit_row/hit_col are undefined-but-stable when hit=0; the bench ignores them.
- new_level: sets refill_pending on any edge, in any state. An in-flight query completes first.
- REFILL (one cycle):
  - alive all ones; bricks_left=50; level=level+1 (mod 16); refill_pending=0.
  - -> IDLE.
  - A refill triggered by level_clear follows DONE via IDLE, so bricks_left reads 50 two cycles after the level_clear pulse.
  - Score is never cleared except by reset.
- Pixel path (independent of the FSM, every cycle): same in_field/row/col math on pix_x/pix_y.
  - pix_brick_on <= in_field && alive[idx], registered.
  - It reflects alive as of the previous edge, so a kill is visible one cycle after UPDATE.
- Arithmetic: all subtractions are 10-bit unsigned. in_field is evaluated before the subtraction result is used, so underflow never indexes alive.

Decomposition:
- Shared package brick_pkg holds:
  - ROWS, COLS, BRICK_W_LOG2, BRICK_H_LOG2, FIELD_Y0, NB;
  - the state enum typedef;
  - the score/level widths.
- One sub-module: brick_locate (combinational xy -> in_field, row, col, idx). Instantiate it twice, once for the query path and once for the pixel path.

Test Plan:
- Reset, then hit_req with (70,40) -> hit_valid 3 cycles later, hit=1, row=0, col=1; score=1; bricks_left=49.
- Repeat (70,40) -> hit=0; score stays 1; bricks_left stays 49. Query (100,200) (below the field, which ends at y=112) -> hit=0.
- After the kill, pix=(70,40) -> pix_brick_on=0 next cycle; pix=(10,40) -> 1; pix=(10,20) -> 0.
- Kill all 50 bricks in sequence:
  - level_clear pulses exactly once, together with the final hit_valid;
  - two cycles later bricks_left=50 and level=1;
  - score=50.
- hit_req asserted during busy cycles -> ignored, no extra hit_valid. new_level during LOOKUP -> query completes, then REFILL; level increments.
- Assert reset during UPDATE -> no hit_valid; bricks_left=50, score=0, busy=0 on the following cycle.
